// File: rtl/cgra_cfg_pkg.sv
// Shared configuration-space definitions for CGRA tile blocks.
//   - Address field positions inside the 32-bit config address.
//   - Default register index of the switch-box configuration word.
//   - Bit positions inside the switch-box configuration word.
package cgra_cfg_pkg;

    // Config address layout: [15:0] tile, [23:16] register index, [31:24] unused.
    localparam int unsigned TileLsb   = 0;
    localparam int unsigned TileW     = 16;
    localparam int unsigned RegIdxLsb = 16;
    localparam int unsigned RegIdxW   = 8;

    localparam logic [RegIdxW-1:0] SbRegIdxDefault = 8'h00;

    // Switch-box configuration word layout.
    localparam int unsigned SbSelLsb    = 10;
    localparam int unsigned SbSelW      = 2;
    localparam int unsigned SbPipeEnBit = 12;

    // Mux select encoding held in config_sb[11:10]; decoded downstream only.
    typedef enum logic [1:0] {
        SelIn00 = 2'd0,
        SelIn20 = 2'd1,
        SelIn30 = 2'd2,
        SelPe0  = 2'd3
    } sb_sel_e;

endpackage

// File: rtl/cfg_reg32.sv
// Addressed 32-bit configuration register with registered read-back.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   tile_id       : static tile identifier matched against the address tile field
//   config_addr   : tile / register-index address
//   config_data   : write data
//   config_write  : one-cycle write strobe
//   config_read   : one-cycle read strobe
//   read_data     : read-back data, held while read_valid is low
//   read_valid    : one-cycle pulse one cycle after config_read
//   cfg_value     : current register contents
module cfg_reg32
    import cgra_cfg_pkg::*;
#(
    parameter int unsigned          TILE_ID_W  = 16,
    parameter logic [RegIdxW-1:0]   SB_REG_IDX = SbRegIdxDefault
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TILE_ID_W-1:0] tile_id,
    input  logic [31:0]          config_addr,
    input  logic [31:0]          config_data,
    input  logic                 config_write,
    input  logic                 config_read,
    output logic [31:0]          read_data,
    output logic                 read_valid,
    output logic [31:0]          cfg_value
);

    logic        hit;
    logic [31:0] value_q;
    logic [31:0] read_data_q;
    logic        read_valid_q;

    // Top address byte carries no meaning for this register.
    logic unused_addr_hi;
    assign unused_addr_hi = ^config_addr[31:24];

    assign hit = (config_addr[TileLsb +: TILE_ID_W] == tile_id) &&
                 (config_addr[RegIdxLsb +: RegIdxW] == SB_REG_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q      <= 32'h0;
            read_data_q  <= 32'h0;
            read_valid_q <= 1'b0;
        end else begin
            if (config_write && hit) begin
                value_q <= config_data;
            end
            read_valid_q <= config_read;
            // Samples value_q before any coincident write lands: read-old.
            if (config_read) begin
                read_data_q <= hit ? value_q : 32'h0;
            end
        end
    end

    assign cfg_value  = value_q;
    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;

endmodule

// File: rtl/sb_config_track.sv
// Switch-box configuration and track output stage for one track.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   tile_id       : static tile identifier
//   config_addr   : config address ([15:0] tile, [23:16] register index)
//   config_data   : config write data
//   config_write  : config write strobe
//   config_read   : config read strobe
//   read_data     : config read-back data
//   read_valid    : read-back qualifier pulse
//   config_sb     : switch-box configuration word to the switch-box mux
//   sb_out_1_0    : switch-box mux output, side 1 track 0
//   track_out_1_0 : track output, pipelined or bypassed per config_sb[12]
module sb_config_track
    import cgra_cfg_pkg::*;
#(
    parameter int unsigned          TILE_ID_W  = 16,
    parameter logic [RegIdxW-1:0]   SB_REG_IDX = SbRegIdxDefault
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TILE_ID_W-1:0] tile_id,
    input  logic [31:0]          config_addr,
    input  logic [31:0]          config_data,
    input  logic                 config_write,
    input  logic                 config_read,
    output logic [31:0]          read_data,
    output logic                 read_valid,
    output logic [31:0]          config_sb,
    input  logic [1:0]           sb_out_1_0,
    output logic [1:0]           track_out_1_0
);

    logic [31:0] sb_word;
    logic [1:0]  pipe_q;

    cfg_reg32 #(
        .TILE_ID_W  (TILE_ID_W),
        .SB_REG_IDX (SB_REG_IDX)
    ) u_sb_reg (
        .clk          (clk),
        .reset        (reset),
        .tile_id      (tile_id),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_write (config_write),
        .config_read  (config_read),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .cfg_value    (sb_word)
    );

    // Free-running capture so enabling the pipeline shows last cycle's value at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q <= 2'b0;
        end else begin
            pipe_q <= sb_out_1_0;
        end
    end

    always_comb begin
        track_out_1_0 = sb_out_1_0;
        if (sb_word[SbPipeEnBit]) begin
            track_out_1_0 = pipe_q;
        end
    end

    assign config_sb = sb_word;

endmodule

// File: tb/tb_sb_config_track.sv
module tb_sb_config_track;

    localparam logic [15:0] Tile   = 16'h0005;
    localparam logic [31:0] HitA   = {8'h00, 8'h00, 16'h0005};
    localparam logic [31:0] MissA  = {8'h00, 8'h00, 16'h0006};

    logic        clk;
    logic        reset;
    logic [15:0] tile_id;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_write;
    logic        config_read;
    logic [31:0] read_data;
    logic        read_valid;
    logic [31:0] config_sb;
    logic [1:0]  sb_out_1_0;
    logic [1:0]  track_out_1_0;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference state: what the spec says is visible after each edge.
    logic [31:0] m_cfg;
    logic [1:0]  m_last_sb;
    logic        m_rv;
    logic [31:0] m_rd;

    sb_config_track #(
        .TILE_ID_W  (16),
        .SB_REG_IDX (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tile_id       (tile_id),
        .config_addr   (config_addr),
        .config_data   (config_data),
        .config_write  (config_write),
        .config_read   (config_read),
        .read_data     (read_data),
        .read_valid    (read_valid),
        .config_sb     (config_sb),
        .sb_out_1_0    (sb_out_1_0),
        .track_out_1_0 (track_out_1_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive after negedge, check the bypass/pipe path, then
    // advance the reference on the edge and check registered outputs after it.
    task automatic cycle(input logic rst, input logic [31:0] addr, input logic [31:0] data,
                         input logic wr, input logic rd, input logic [1:0] sb);
        logic hit;
        reset        = rst;
        config_addr  = addr;
        config_data  = data;
        config_write = wr;
        config_read  = rd;
        sb_out_1_0   = sb;
        #1;
        check_eq("track_out", {30'b0, track_out_1_0},
                 {30'b0, (m_cfg[12] ? m_last_sb : sb)});
        @(posedge clk);
        hit = (addr[15:0] == tile_id) && (addr[23:16] == 8'h00);
        if (rst) begin
            m_cfg     = 32'h0;
            m_last_sb = 2'b0;
            m_rv      = 1'b0;
            m_rd      = 32'h0;
        end else begin
            m_rv = rd;
            if (rd) m_rd = hit ? m_cfg : 32'h0;
            if (wr && hit) m_cfg = data;
            m_last_sb = sb;
        end
        @(negedge clk);
        check_eq("config_sb", config_sb, m_cfg);
        check_eq("read_valid", {31'b0, read_valid}, {31'b0, m_rv});
        check_eq("read_data", read_data, m_rd);
    endtask

    task automatic idle(input logic [1:0] sb);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, sb);
    endtask

    initial begin
        tile_id      = Tile;
        reset        = 1'b1;
        config_addr  = 32'h0;
        config_data  = 32'h0;
        config_write = 1'b0;
        config_read  = 1'b0;
        sb_out_1_0   = 2'b0;
        m_cfg        = 32'h0;
        m_last_sb    = 2'b0;
        m_rv         = 1'b0;
        m_rd         = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_config_sb", config_sb, 32'h0);
        check_eq("rst_read_valid", {31'b0, read_valid}, 32'h0);
        check_eq("rst_read_data", read_data, 32'h0);
        cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 2'd3);

        // Basic write and read-back.
        cycle(1'b0, HitA, 32'h00001C00, 1'b1, 1'b0, 2'd1);
        check_eq("wr_basic", config_sb, 32'h00001C00);
        cycle(1'b0, HitA, 32'h0, 1'b0, 1'b1, 2'd2);
        check_eq("rd_basic", read_data, 32'h00001C00);
        idle(2'd0);

        // Tile mismatch: write ignored, read returns zero with a valid pulse.
        cycle(1'b0, MissA, 32'hDEADBEEF, 1'b1, 1'b0, 2'd0);
        check_eq("wr_miss", config_sb, 32'h00001C00);
        cycle(1'b0, MissA, 32'h0, 1'b0, 1'b1, 2'd0);
        check_eq("rd_miss_valid", {31'b0, read_valid}, 32'h1);
        check_eq("rd_miss_data", read_data, 32'h0);
        // Register index mismatch.
        cycle(1'b0, {8'h00, 8'h01, Tile}, 32'h12345678, 1'b1, 1'b0, 2'd0);
        check_eq("wr_idx_miss", config_sb, 32'h00001C00);

        // Read-old on simultaneous write and read.
        cycle(1'b0, HitA, 32'h5, 1'b1, 1'b0, 2'd0);
        cycle(1'b0, HitA, 32'hA, 1'b1, 1'b1, 2'd0);
        check_eq("rold_data", read_data, 32'h5);
        check_eq("rold_cfg", config_sb, 32'hA);

        // Pipeline enabled, then bypass.
        cycle(1'b0, HitA, 32'h00001000, 1'b1, 1'b0, 2'd2);
        for (int i = 0; i < 4; i++) idle(2'(i));
        cycle(1'b0, HitA, 32'h0, 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 4; i++) idle(2'(i));

        // Reset wins over coincident write and read; no stale read_valid.
        cycle(1'b0, HitA, 32'h0, 1'b0, 1'b1, 2'd0);
        cycle(1'b1, HitA, 32'hFFFFFFFF, 1'b1, 1'b1, 2'd1);
        check_eq("rst_pri_cfg", config_sb, 32'h0);
        idle(2'd2);
        check_eq("rst_pri_rv1", {31'b0, read_valid}, 32'h0);
        idle(2'd3);
        check_eq("rst_pri_rv2", {31'b0, read_valid}, 32'h0);

        // Back-to-back reads, config changing in between.
        cycle(1'b0, HitA, 32'h11110000, 1'b1, 1'b0, 2'd0);
        cycle(1'b0, HitA, 32'h0, 1'b0, 1'b1, 2'd0);
        cycle(1'b0, HitA, 32'h22220000, 1'b1, 1'b1, 2'd0);
        cycle(1'b0, HitA, 32'h0, 1'b0, 1'b1, 2'd0);
        check_eq("b2b_last", read_data, 32'h22220000);
        idle(2'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = $urandom;
            if ($urandom_range(1, 0) == 1) a[23:16] = 8'h00;
            if ($urandom_range(3, 0) != 0) a[15:0] = Tile;
            d = $urandom;
            if ($urandom_range(1, 0) == 1) d[12] = ~d[12];
            cycle(($urandom_range(39, 0) == 0), a, d,
                  ($urandom_range(2, 0) == 0), ($urandom_range(1, 0) == 1),
                  2'($urandom_range(3, 0)));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Absolute backstop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
